// File: rtl/ddr_mgr_pkg.sv
// Shared ddr2_mgr definitions: address field widths, fill FSM encoding, default fill word.
// Also imported by the read-checker, so fields here must stay in step with it.
package ddr_mgr_pkg;

  localparam int ROW_W  = 13;
  localparam int COL_W  = 10;
  localparam int BANK_W = 2;
  localparam int ADDR_W = ROW_W + COL_W + BANK_W;
  localparam int XLEN_W = 10;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] DEF_PATTERN = 32'hFDCB8610;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFR  = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } fill_state_t;

  // Every row burst starts at column 0, bank 0.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] row);
    return {row, {COL_W{1'b0}}, {BANK_W{1'b0}}};
  endfunction

  function automatic logic [DATA_W-1:0] tag_word(input logic [ROW_W-1:0] row,
                                                 input logic [XLEN_W-1:0] idx);
    return {3'b000, row, 6'b000000, idx};
  endfunction

endpackage

// File: rtl/ddr2_fill_gen_if.sv
// ddr2_mgr write-port bus: request/grant handshake plus the word pull stream.
interface ddr2_fill_gen_if;
  import ddr_mgr_pkg::*;

  logic              wr_mem_req;
  logic [ADDR_W-1:0] wr_mem_addr;
  logic [XLEN_W-1:0] wr_xfr_len;
  logic              wr_mem_grant;
  logic              wr_data_req;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_mem_req, wr_mem_addr, wr_xfr_len, wr_data,
    input  wr_mem_grant, wr_data_req
  );

  modport slave (
    input  wr_mem_req, wr_mem_addr, wr_xfr_len, wr_data,
    output wr_mem_grant, wr_data_req
  );

endinterface

// File: rtl/ddr2_fill_gen.sv
// Fills DDR2 rows 0..MAX_ROW with one XFR_LEN-word burst per row through the
// ddr2_mgr write port, using a constant word or a {row, word} tag.
module ddr2_fill_gen
  import ddr_mgr_pkg::*;
#(
  parameter logic [XLEN_W-1:0] XFR_LEN = 10'h200,
  parameter logic [ROW_W-1:0]  MAX_ROW = 13'h02FF,
  parameter logic [DATA_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pattern_sel,
  ddr2_fill_gen_if.master wr_if,
  output logic            busy,
  output logic            fill_done,
  output logic            proto_err
);

  localparam logic [XLEN_W-1:0] LAST_IDX = XFR_LEN - XLEN_W'(1);

  fill_state_t       r_state;
  fill_state_t       w_state_next;
  logic [ROW_W-1:0]  r_row;
  logic [XLEN_W-1:0] r_word_idx;
  logic              r_pat_sel;
  logic              r_fill_done;
  logic              r_proto_err;

  logic              w_start_ok;
  logic              w_grant_ok;
  logic              w_data_ok;
  logic              w_last_word;
  logic              w_last_row;
  logic              w_violation;

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [XLEN_W-1:0] w_len;
  logic              w_busy;

  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_grant_ok  = (r_state == ST_REQ) && wr_if.wr_mem_grant;
  assign w_data_ok   = (r_state == ST_XFR) && wr_if.wr_data_req;
  assign w_last_word = (r_word_idx == LAST_IDX);
  assign w_last_row  = (r_row == MAX_ROW);
  // A data pull coinciding with the grant lands here too: flagged, never counted.
  assign w_violation = (wr_if.wr_data_req && (r_state != ST_XFR)) ||
                       (wr_if.wr_mem_grant && (r_state != ST_REQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_REQ;
      ST_REQ:  if (wr_if.wr_mem_grant) w_state_next = ST_XFR;
      ST_XFR:  if (wr_if.wr_data_req && w_last_word) w_state_next = ST_NEXT;
      ST_NEXT: w_state_next = w_last_row ? ST_DONE : ST_REQ;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req  = 1'b0;
    w_addr = '0;
    w_len  = '0;
    w_busy = 1'b0;
    case (r_state)
      ST_REQ: begin
        w_req  = 1'b1;
        w_addr = row_addr(r_row);
        w_len  = XFR_LEN;
        w_busy = 1'b1;
      end
      ST_XFR, ST_NEXT: w_busy = 1'b1;
      default: ;
    endcase
  end

  // Row/word counters and sticky flags; row only advances out of ST_NEXT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row       <= '0;
      r_word_idx  <= '0;
      r_pat_sel   <= 1'b0;
      r_fill_done <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_row       <= '0;
        r_word_idx  <= '0;
        r_pat_sel   <= pattern_sel;
        r_fill_done <= 1'b0;
      end
      if (w_grant_ok) begin
        r_word_idx <= '0;
      end
      if (w_data_ok) begin
        r_word_idx <= w_last_word ? '0 : r_word_idx + XLEN_W'(1);
      end
      if ((r_state == ST_NEXT) && !w_last_row) begin
        r_row <= r_row + ROW_W'(1);
      end
      if ((r_state == ST_NEXT) && w_last_row) begin
        r_fill_done <= 1'b1;
      end
      r_proto_err <= w_violation || (r_proto_err && !w_start_ok);
    end
  end

  assign wr_if.wr_mem_req  = w_req;
  assign wr_if.wr_mem_addr = w_addr;
  assign wr_if.wr_xfr_len  = w_len;
  assign wr_if.wr_data     = r_pat_sel ? tag_word(r_row, r_word_idx) : PATTERN;

  assign busy      = w_busy;
  assign fill_done = r_fill_done;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_ddr2_fill_gen.sv
// Randomized bench for ddr2_fill_gen: a driver plays ddr2_mgr and queues expected
// requests/words from a row/word model; negedge monitors pop and compare.
module tb_ddr2_fill_gen;

  localparam int          XFR_A = 128;
  localparam int          MAX_A = 11;
  localparam logic [31:0] PAT   = 32'hFDCB8610;

  logic clk;
  logic rst;
  logic start_a, psel_a, busy_a, done_a, perr_a;
  logic start_b, psel_b, busy_b, done_b, perr_b;
  logic legit_a;

  ddr2_fill_gen_if ifa();
  ddr2_fill_gen_if ifb();

  ddr2_fill_gen #(.XFR_LEN(10'd128), .MAX_ROW(13'd11)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pattern_sel(psel_a), .wr_if(ifa),
    .busy(busy_a), .fill_done(done_a), .proto_err(perr_a)
  );

  ddr2_fill_gen #(.XFR_LEN(10'd1), .MAX_ROW(13'd2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pattern_sel(psel_b), .wr_if(ifb),
    .busy(busy_b), .fill_done(done_b), .proto_err(perr_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        prev_req_a = 1'b0;
  logic        prev_req_b = 1'b0;
  int          req_cnt_b  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_req"},  64'(ifa.wr_mem_req),  64'd0);
    chk({tag, "_addr"}, 64'(ifa.wr_mem_addr), 64'd0);
    chk({tag, "_len"},  64'(ifa.wr_xfr_len),  64'd0);
    chk({tag, "_busy"}, 64'(busy_a),          64'd0);
    chk({tag, "_done"}, 64'(done_a),          64'd0);
    chk({tag, "_perr"}, 64'(perr_a),          64'd0);
    chk({tag, "_data"}, 64'(ifa.wr_data),     64'(PAT));
  endtask

  // Scoreboard side for DUT A: one line per accepted request.
  always @(negedge clk) begin
    logic [24:0] ea;
    logic [31:0] ed;
    if (!rst) begin
      if (ifa.wr_mem_req && !prev_req_a) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req actual addr=%h required=no request", ifa.wr_mem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("req_addr", 64'(ifa.wr_mem_addr), 64'(ea));
          chk("req_len", 64'(ifa.wr_xfr_len), 64'(XFR_A));
          $display("req addr=%h len=%0d", ifa.wr_mem_addr, ifa.wr_xfr_len);
        end
      end
      if (ifa.wr_data_req && legit_a) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word actual=%h required=no word", ifa.wr_data);
        end else begin
          ed = exp_data_q.pop_front();
          chk("wr_data", 64'(ifa.wr_data), 64'(ed));
        end
      end
    end
    prev_req_a = ifa.wr_mem_req;
  end

  always @(negedge clk) begin
    if (!rst && ifb.wr_mem_req && !prev_req_b) req_cnt_b++;
    prev_req_b = ifb.wr_mem_req;
  end

  // Driver plays ddr2_mgr; caller stands #1 after a rising edge.
  task automatic run_fill(input bit psel, input int gap_max, input int lat_min,
                          input int lat_max, input bit do_abort);
    int t;
    repeat (2) begin @(posedge clk); #1; end
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int r = 0; r <= MAX_A; r++) exp_addr_q.push_back(25'(r) << 12);
    start_a = 1'b1;
    psel_a  = psel;
    @(posedge clk); #1;
    start_a = 1'b0;
    psel_a  = ~psel;
    chk("start_busy", 64'(busy_a), 64'd1);
    chk("start_clr_done", 64'(done_a), 64'd0);
    chk("start_clr_perr", 64'(perr_a), 64'd0);
    for (int r = 0; r <= MAX_A; r++) begin
      t = 0;
      while (!ifa.wr_mem_req && t < 50) begin @(posedge clk); #1; t++; end
      chk("req_wait", 64'(ifa.wr_mem_req), 64'd1);
      if (!ifa.wr_mem_req) return;
      repeat ($urandom_range(lat_max, lat_min)) begin @(posedge clk); #1; end
      ifa.wr_mem_grant = 1'b1;
      @(posedge clk); #1;
      ifa.wr_mem_grant = 1'b0;
      chk("req_drop", 64'(ifa.wr_mem_req), 64'd0);
      for (int w = 0; w < XFR_A; w++) begin
        repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
        if (do_abort && r == 10 && w == 100) begin
          rst = 1'b1;
          @(posedge clk); #1;
          check_reset_a("abort");
          rst = 1'b0;
          exp_addr_q.delete();
          exp_data_q.delete();
          repeat (5) begin @(posedge clk); #1; end
          chk("abort_no_req", 64'(ifa.wr_mem_req), 64'd0);
          chk("abort_idle", 64'(busy_a), 64'd0);
          return;
        end
        if (psel && r == 5 && w == 17) chk("tag_r5_w17", 64'(ifa.wr_data), 64'h0005_0011);
        exp_data_q.push_back(psel ? ((32'(r) << 16) | 32'(w)) : PAT);
        legit_a = 1'b1;
        ifa.wr_data_req = 1'b1;
        @(posedge clk); #1;
        legit_a = 1'b0;
        ifa.wr_data_req = 1'b0;
      end
    end
    t = 0;
    while (!done_a && t < 10) begin @(posedge clk); #1; t++; end
    chk("fill_done", 64'(done_a), 64'd1);
    chk("done_busy", 64'(busy_a), 64'd0);
    chk("fill_perr", 64'(perr_a), 64'd0);
    chk("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    chk("data_q_empty", 64'(exp_data_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1;
    start_a = 1'b0; psel_a = 1'b0; legit_a = 1'b0;
    start_b = 1'b0; psel_b = 1'b0;
    ifa.wr_mem_grant = 1'b0; ifa.wr_data_req = 1'b0;
    ifb.wr_mem_grant = 1'b0; ifb.wr_data_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Grant while idle is a protocol violation.
    ifa.wr_mem_grant = 1'b1;
    @(posedge clk); #1;
    ifa.wr_mem_grant = 1'b0;
    chk("grant_idle_perr", 64'(perr_a), 64'd1);
    chk("grant_idle_busy", 64'(busy_a), 64'd0);

    run_fill(1'b0, 0, 3, 3, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    chk("done_sticky", 64'(done_a), 64'd1);

    run_fill(1'b1, 4, 0, 5, 1'b0);

    repeat (2) begin @(posedge clk); #1; end
    legit_a = 1'b0;
    ifa.wr_data_req = 1'b1;
    @(posedge clk); #1;
    ifa.wr_data_req = 1'b0;
    chk("dreq_idle_perr", 64'(perr_a), 64'd1);
    chk("dreq_idle_busy", 64'(busy_a), 64'd0);
    chk("dreq_idle_req", 64'(ifa.wr_mem_req), 64'd0);
    chk("dreq_idle_done", 64'(done_a), 64'd1);

    run_fill(1'b0, 4, 1, 4, 1'b0);
    run_fill(1'b1, 0, 3, 3, 1'b1);
    run_fill(1'b1, 1, 0, 2, 1'b0);

    // Short instance: three single-word rows, extra starts while busy.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int r = 0; r <= 2; r++) begin
      t = 0;
      while (!ifb.wr_mem_req && t < 20) begin @(posedge clk); #1; t++; end
      chk("b_req_wait", 64'(ifb.wr_mem_req), 64'd1);
      chk("b_addr", 64'(ifb.wr_mem_addr), 64'(25'(r) << 12));
      chk("b_len", 64'(ifb.wr_xfr_len), 64'd1);
      if (r == 1) start_b = 1'b1;
      ifb.wr_mem_grant = 1'b1;
      @(posedge clk); #1;
      ifb.wr_mem_grant = 1'b0;
      start_b = 1'b0;
      if (r == 2) start_b = 1'b1;
      chk("b_data", 64'(ifb.wr_data), 64'(PAT));
      ifb.wr_data_req = 1'b1;
      @(posedge clk); #1;
      ifb.wr_data_req = 1'b0;
      start_b = 1'b0;
      $display("b row=%0d granted", r);
    end
    t = 0;
    while (!done_b && t < 10) begin @(posedge clk); #1; t++; end
    chk("b_done", 64'(done_b), 64'd1);
    chk("b_busy", 64'(busy_b), 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("b_grants", 64'(req_cnt_b), 64'd3);
    chk("b_done_hold", 64'(done_b), 64'd1);
    chk("b_perr", 64'(perr_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
